// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage behind the ALU.
// lw/sw use alu_out as a byte address into a word-addressed synchronous RAM.
// Every other op passes alu_out straight through as the writeback value.
// A one-entry output register feeds writeback.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_valid/out_valid may be raised regardless of ready. Once raised,
// a valid and its payload stay stable until the transfer. ready may depend
// combinationally on the downstream ready, never on the same side's valid.
module mem_access_stage #(
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [5:0] OP_LW      = 6'd35,
  parameter logic [5:0] OP_SW      = 6'd43
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  OpCode,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic        reg_write,
  input  logic [4:0]  wb_reg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg_out,
  output logic        wb_en,
  output logic        misalign,
  output logic        state_dbg
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } state_t;

  state_t state;

  logic [31:0]           mem [0:DEPTH-1];
  logic [31:0]           rd_data;
  logic                  accept;
  logic                  is_lw;
  logic                  is_sw;
  logic                  aligned;
  logic [DEPTH_LOG2-1:0] word_idx;

  // Only the word-index bits select a RAM word; upper address bits wrap.
  assign word_idx  = alu_out[DEPTH_LOG2+1:2];
  assign aligned   = (alu_out[1:0] == 2'b00);
  assign is_lw     = (OpCode == OP_LW);
  assign is_sw     = (OpCode == OP_SW);

  // A new op can enter only from IDLE, and only when the output slot is free
  // or is being drained on this same edge.
  assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign state_dbg = (state == LOAD_WAIT);

  // Data RAM, read-first. A write lands at this edge, so a lw accepted on the
  // following edge already sees the new value.
  always_ff @(posedge clk) begin
    if (accept && aligned && is_sw) begin
      mem[word_idx] <= store_data;
    end
    if (accept && aligned && is_lw) begin
      rd_data <= mem[word_idx];
    end
  end

  // Stage control FSM and output entry register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      wb_data    <= 32'd0;
      wb_reg_out <= 5'd0;
      wb_en      <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wb_reg_out <= wb_reg;
            wb_data    <= alu_out;
            if ((is_lw || is_sw) && !aligned) begin
              // Misaligned memory op: no RAM access, flagged entry next edge.
              wb_en     <= 1'b0;
              misalign  <= 1'b1;
              out_valid <= 1'b1;
            end else if (is_lw) begin
              // The slot is free (or drained this edge); the load data
              // arrives one edge later.
              wb_en     <= 1'b0;
              misalign  <= 1'b0;
              out_valid <= 1'b0;
              state     <= LOAD_WAIT;
            end else if (is_sw) begin
              wb_en     <= 1'b0;
              misalign  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              // Register zero is never written.
              wb_en     <= reg_write && (wb_reg != 5'd0);
              misalign  <= 1'b0;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            // The entry was consumed and nothing replaces it.
            out_valid <= 1'b0;
          end
        end
        LOAD_WAIT: begin
          wb_data   <= rd_data;
          wb_en     <= (wb_reg_out != 5'd0);
          misalign  <= 1'b0;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
